// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan scheduler in front of sar_ctrl: walks the latched channel mask, powers the
// ADC, waits for mux settling, issues soc, averages 2^avg_log2 conversions per channel and hands
// each averaged result downstream over a valid/ready port.
module adc_scan_sequencer #(
    parameter int unsigned SIZE    = 12,
    parameter int unsigned NCH     = 8,
    parameter int unsigned CHW     = 3,
    parameter int unsigned WARMUP  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            continuous,
    input  logic [NCH-1:0]  ch_mask,
    input  logic [3:0]      settle,
    input  logic [1:0]      avg_log2,
    output logic            adc_en,
    output logic            soc,
    input  logic            eoc,
    input  logic [SIZE-1:0] adc_data,
    output logic [CHW-1:0]  mux_sel,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [SIZE-1:0] res_data,
    output logic [CHW-1:0]  res_ch,
    output logic            err_timeout
);

    localparam int unsigned ACCW = SIZE + 3;
    localparam int unsigned TMAX = (WARMUP > TIMEOUT) ? WARMUP : TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        StIdle, StWarm, StSelect, StSettle, StSoc, StConv, StOut
    } state_e;

    state_e          state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [1:0]      avg_q, avg_d;
    logic            first_q, first_d;      // pointer is "-1": search starts at index 0
    logic [TW-1:0]   tmr_q, tmr_d;          // warm-up, settle and watchdog timer
    logic [3:0]      cnt_q, cnt_d;          // samples collected on the current channel
    logic [ACCW-1:0] acc_q, acc_d;
    logic            adc_en_q, adc_en_d;
    logic            soc_q, soc_d;
    logic [CHW-1:0]  mux_sel_q, mux_sel_d;
    logic            busy_q, busy_d;
    logic            res_valid_q, res_valid_d;
    logic [SIZE-1:0] res_data_q, res_data_d;
    logic [CHW-1:0]  res_ch_q, res_ch_d;
    logic            err_q, err_d;

    logic            found;
    logic [CHW-1:0]  found_idx, low_idx;
    logic [TW:0]     tmr_inc;

    // Next enabled channel above the current pointer, plus the lowest enabled one for wrapping.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        low_idx   = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = CHW'(i);
                if (first_q || (i > int'(mux_sel_q))) begin
                    found     = 1'b1;
                    found_idx = CHW'(i);
                end
            end
        end
    end

    // Scan FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        avg_d       = avg_q;
        first_d     = first_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        adc_en_d    = adc_en_q;
        mux_sel_d   = mux_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ch_d    = res_ch_q;
        err_d       = 1'b0;
        tmr_inc     = {1'b0, tmr_q} + (TW + 1)'(1);

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        if (stop && (state_q != StIdle)) begin
            // Abort wins over everything; a pending result stays until accepted.
            state_d  = StIdle;
            adc_en_d = 1'b0;
            acc_d    = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && (ch_mask != '0)) begin
                        mask_d   = ch_mask;
                        avg_d    = avg_log2;
                        adc_en_d = 1'b1;
                        tmr_d    = '0;
                        state_d  = StWarm;
                    end
                end
                StWarm: begin
                    if (tmr_q == TW'(WARMUP - 1)) begin
                        first_d = 1'b1;
                        tmr_d   = '0;
                        state_d = StSelect;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                StSelect: begin
                    if (found || continuous) begin
                        mux_sel_d = found ? found_idx : low_idx;
                        first_d   = 1'b0;
                        acc_d     = '0;
                        cnt_d     = '0;
                        tmr_d     = '0;
                        state_d   = (settle == 4'd0) ? StSoc : StSettle;
                    end else begin
                        adc_en_d = 1'b0;
                        state_d  = StIdle;
                    end
                end
                StSettle: begin
                    // settle is read live; >= tolerates it shrinking mid-count
                    if (tmr_inc >= (TW + 1)'(settle)) begin
                        state_d = StSoc;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                StSoc: begin
                    tmr_d   = TW'(1);
                    state_d = StConv;
                end
                StConv: begin
                    if (eoc) begin
                        acc_d = acc_q + ACCW'(adc_data);
                        cnt_d = cnt_q + 4'd1;
                        tmr_d = '0;
                        if ((cnt_q + 4'd1) == (4'd1 << avg_q)) begin
                            state_d = StOut;
                        end else begin
                            state_d = (settle == 4'd0) ? StSoc : StSettle;
                        end
                    end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                        err_d    = 1'b1;
                        adc_en_d = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                StOut: begin
                    // Load when the slot is empty or is being emptied this cycle.
                    if (!res_valid_q || res_ready) begin
                        res_data_d  = SIZE'(acc_q >> avg_q);
                        res_ch_d    = mux_sel_q;
                        res_valid_d = 1'b1;
                        state_d     = StSelect;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        soc_d  = (state_d == StSoc);
        busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            avg_q       <= '0;
            first_q     <= 1'b0;
            tmr_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            adc_en_q    <= 1'b0;
            soc_q       <= 1'b0;
            mux_sel_q   <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            avg_q       <= avg_d;
            first_q     <= first_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            adc_en_q    <= adc_en_d;
            soc_q       <= soc_d;
            mux_sel_q   <= mux_sel_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ch_q    <= res_ch_d;
            err_q       <= err_d;
        end
    end

    assign adc_en      = adc_en_q;
    assign soc         = soc_q;
    assign mux_sel     = mux_sel_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_ch      = res_ch_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: emulated sar_ctrl responder, event monitor and an arithmetic
// reference model of the scan order and averaging.
module tb_adc_scan_sequencer;

    localparam int WARMUP  = 16;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic [3:0]  settle = '0;
    logic [1:0]  avg_log2 = '0;
    logic        eoc = 1'b0;
    logic [11:0] adc_data = '0;
    logic        res_ready = 1'b0;
    logic        adc_en, soc, busy, res_valid, err_timeout;
    logic [2:0]  mux_sel, res_ch;
    logic [11:0] res_data;

    int checks = 0;
    int failures = 0;

    // Monitor/responder state (written only by the monitor process)
    int          cyc = 0;
    int          soc_cnt = 0, eoc_cnt = 0, got_cnt = 0, err_cnt = 0, err_cyc = 0;
    int          soc_cyc [1024];
    int          eoc_cyc [1024];
    logic [14:0] got [1024];
    int          sidx = 0;
    int          pend = 0;
    // Responder configuration (written only by the stimulus block)
    logic [11:0] smp [256];
    int          lat = 2;
    bit          rsp_en = 1'b1;

    adc_scan_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .settle     (settle),
        .avg_log2   (avg_log2),
        .adc_en     (adc_en),
        .soc        (soc),
        .eoc        (eoc),
        .adc_data   (adc_data),
        .mux_sel    (mux_sel),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ch     (res_ch),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Sample everything mid-cycle, then drive the emulated sar_ctrl just after the next edge.
    always begin
        @(negedge clk);
        cyc++;
        if (soc) begin
            soc_cyc[soc_cnt % 1024] = cyc;
            soc_cnt++;
            if (rsp_en) pend = lat;
        end
        if (eoc) begin
            eoc_cyc[eoc_cnt % 1024] = cyc;
            eoc_cnt++;
        end
        if (res_valid && res_ready) begin
            got[got_cnt % 1024] = {res_ch, res_data};
            got_cnt++;
        end
        if (err_timeout) begin
            err_cyc = cyc;
            err_cnt++;
        end
        @(posedge clk);
        #1;
        eoc = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                eoc      = 1'b1;
                adc_data = smp[sidx];
                sidx     = (sidx + 1) % 256;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One non-continuous scan with res_ready held high, checked against the model.
    task automatic run_scan(input string tag, input logic [7:0] m, input int av, input int st,
                            input int lt, input bit maxv);
        int          base, sb, gb, k, sum, t_start;
        logic [14:0] exp_q [$];
        base = sidx;
        sb   = soc_cnt;
        gb   = got_cnt;
        for (int i = 0; i < 64; i++) smp[(base + i) % 256] = maxv ? 12'hFFF : 12'($urandom);
        k = 0;
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch]) begin
                sum = 0;
                for (int j = 0; j < (1 << av); j++) begin
                    sum += int'(smp[(base + k) % 256]);
                    k++;
                end
                exp_q.push_back({3'(ch), 12'(sum >> av)});
            end
        end
        ch_mask    = m;
        avg_log2   = 2'(av);
        settle     = 4'(st);
        lat        = lt;
        res_ready  = 1'b1;
        continuous = 1'b0;
        start      = 1'b1;
        t_start    = cyc + 1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 8000 && busy; i++) step(1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_adc_en"}, 32'(adc_en), 32'd0);
        chk({tag, "_nres"}, 32'(got_cnt - gb), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk({tag, "_res"}, 32'(got[(gb + i) % 1024]), 32'(exp_q[i]));
        end
        chk({tag, "_nsoc"}, 32'(soc_cnt - sb), 32'(k));
        chk({tag, "_first_soc"}, 32'(soc_cyc[sb % 1024]), 32'(t_start + WARMUP + 2 + st));
        step(3);
    endtask

    initial begin
        int base, sb, eb, gb, st;

        // Reset state
        step(2);
        chk("reset_outs", 32'({adc_en, soc, mux_sel, busy, res_valid, res_data, res_ch,
                               err_timeout}), 32'd0);
        rst_n = 1'b1;
        step(2);

        // Three-channel single pass, no averaging
        run_scan("scan_a4", 8'hA4, 0, int'($urandom_range(0, 15)), 3, 1'b0);

        // Four-sample average on ch0, with eoc-to-soc spacing
        st = int'($urandom_range(0, 15));
        sb = soc_cnt;
        eb = eoc_cnt;
        run_scan("avg4", 8'h01, 2, st, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("avg4_gap", 32'(soc_cyc[(sb + i + 1) % 1024] - eoc_cyc[(eb + i) % 1024]),
                32'(st + 1));
        end

        // Full-scale input with 8x averaging must not overflow
        run_scan("max8", 8'h10, 3, 2, 1, 1'b1);

        // Randomized scans
        for (int t = 0; t < 4; t++) begin
            run_scan("rand", 8'($urandom_range(1, 255)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), int'($urandom_range(1, 6)), 1'b0);
        end

        // Continuous scan under backpressure, then release and wrap
        base = sidx;
        sb   = soc_cnt;
        gb   = got_cnt;
        for (int i = 0; i < 64; i++) smp[(base + i) % 256] = 12'($urandom);
        ch_mask    = 8'h81;
        avg_log2   = 2'd0;
        settle     = 4'($urandom_range(0, 15));
        lat        = 2;
        res_ready  = 1'b0;
        continuous = 1'b1;
        start      = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 500 && !res_valid; i++) step(1);
        chk("cont_first_ch", 32'(res_ch), 32'd0);
        chk("cont_first_data", 32'(res_data), 32'(smp[base]));
        step(200);
        chk("cont_hold_valid", 32'(res_valid), 32'd1);
        chk("cont_hold_ch", 32'(res_ch), 32'd0);
        chk("cont_hold_data", 32'(res_data), 32'(smp[base]));
        chk("cont_stall_nsoc", 32'(soc_cnt - sb), 32'd2);
        chk("cont_stall_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        for (int i = 0; i < 500 && (got_cnt - gb) < 3; i++) step(1);
        stop = 1'b1;
        step(1);
        stop       = 1'b0;
        continuous = 1'b0;
        step(10);
        chk("cont_res0", 32'(got[gb % 1024]), 32'({3'd0, smp[base]}));
        chk("cont_res1", 32'(got[(gb + 1) % 1024]), 32'({3'd7, smp[(base + 1) % 256]}));
        chk("cont_res2", 32'(got[(gb + 2) % 1024]), 32'({3'd0, smp[(base + 2) % 256]}));
        chk("cont_stop_busy", 32'(busy), 32'd0);

        // Stop during settle of the second channel with a result pending
        base = sidx;
        sb   = soc_cnt;
        for (int i = 0; i < 64; i++) smp[(base + i) % 256] = 12'($urandom);
        ch_mask   = 8'h06;
        avg_log2  = 2'd0;
        settle    = 4'd8;
        lat       = 2;
        res_ready = 1'b0;
        start     = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 500 && !res_valid; i++) step(1);
        step(2);
        chk("stop_mux_sel", 32'(mux_sel), 32'd2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_adc_en", 32'(adc_en), 32'd0);
        step(30);
        chk("stop_nsoc", 32'(soc_cnt - sb), 32'd1);
        chk("stop_pending", 32'({res_valid, res_ch, res_data}), 32'({1'b1, 3'd1, smp[base]}));
        res_ready = 1'b1;
        step(1);
        chk("stop_delivered", 32'(got[(got_cnt - 1) % 1024]), 32'({3'd1, smp[base]}));
        chk("stop_valid_clr", 32'(res_valid), 32'd0);

        // Watchdog: eoc never arrives
        rsp_en   = 1'b0;
        eb       = err_cnt;
        ch_mask  = 8'h04;
        settle   = 4'($urandom_range(0, 15));
        start    = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 1000 && err_cnt == eb; i++) step(1);
        chk("to_delay", 32'(err_cyc - soc_cyc[(soc_cnt - 1) % 1024]), 32'(TIMEOUT));
        chk("to_adc_en", 32'(adc_en), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        step(2);
        chk("to_one_pulse", 32'(err_cnt - eb), 32'd1);
        rsp_en = 1'b1;

        // Asynchronous reset while a conversion is outstanding
        lat      = 30;
        ch_mask  = 8'h01;
        settle   = 4'd0;
        avg_log2 = 2'd0;
        sb       = soc_cnt;
        start    = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 200 && soc_cnt == sb; i++) step(1);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("rst_conv_outs", 32'({adc_en, soc, mux_sel, busy, res_valid, res_data, res_ch,
                                  err_timeout}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(60);
        chk("rst_conv_nsoc", 32'(soc_cnt - sb), 32'd1);
        chk("rst_conv_busy", 32'(busy), 32'd0);
        chk("rst_conv_valid", 32'(res_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
